// File: rtl/conv_window_sequencer_if.sv
// rtl/conv_window_sequencer_if.sv - control, product-stream, accumulator and result signals of the window sequencer
interface conv_window_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [CNT_W-1:0]  num_windows;
  logic              busy;
  logic              done;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              acc_clear;
  logic              acc_en;
  logic [DATA_W-1:0] acc_in;
  logic [DATA_W-1:0] acc_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;

  modport master (
    output start, num_windows, pix_valid, pix_data, acc_out, out_ready,
    input  busy, done, pix_ready, acc_clear, acc_en, acc_in, out_valid, out_data, out_ovf
  );

  modport slave (
    input  start, num_windows, pix_valid, pix_data, acc_out, out_ready,
    output busy, done, pix_ready, acc_clear, acc_en, acc_in, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - sequences an external accumulator through KSIZE*KSIZE-term windows of a frame
// Define CONV_SEQ_OVF_EN to add per-window sticky signed-overflow detection on out_ovf.
module conv_window_sequencer #(
  parameter int DATA_W = 32,
  parameter int KSIZE  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_window_sequencer_if.slave bus
);
  localparam int TAPS  = KSIZE * KSIZE;
  localparam int TAP_W = $clog2(TAPS + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_SETTLE, S_OUT} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  win_q;
  logic [TAP_W-1:0]  tap_q;
  logic              busy_q;
  logic              done_q;
  logic              pix_ready_q;
  logic              acc_clear_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic accept_d;
  logic tap_last_d;
  logic win_last_d;

  assign accept_d   = pix_ready_q && bus.pix_valid;
  assign tap_last_d = (tap_q == TAP_W'(TAPS - 1));
  assign win_last_d = (win_q == count_q - CNT_W'(1));

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pix_ready = pix_ready_q;
  assign bus.acc_clear = acc_clear_q;
  assign bus.acc_en    = accept_d;
  assign bus.acc_in    = bus.pix_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      win_q       <= '0;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      acc_clear_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      acc_clear_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_windows != '0) begin
              count_q     <= bus.num_windows;
              win_q       <= '0;
              busy_q      <= 1'b1;
              acc_clear_q <= 1'b1;
              state_q     <= S_CLEAR;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          tap_q       <= '0;
          pix_ready_q <= 1'b1;
          state_q     <= S_ACCUM;
        end
        S_ACCUM: begin
          if (accept_d) begin
            tap_q <= tap_q + TAP_W'(1);
            if (tap_last_d) begin
              pix_ready_q <= 1'b0;
              state_q     <= S_SETTLE;
            end
          end
        end
        // acc_out already includes the last term here: the accumulator updated on the accepting edge
        S_SETTLE: begin
          out_data_q  <= bus.acc_out;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (win_last_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              win_q       <= win_q + CNT_W'(1);
              acc_clear_q <= 1'b1;
              state_q     <= S_CLEAR;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_OVF_EN
  logic [DATA_W-1:0] sum_d;
  logic              term_ovf_d;
  logic              win_ovf_q;
  logic              out_ovf_q;

  assign sum_d      = bus.acc_out + bus.pix_data;
  assign term_ovf_d = (bus.acc_out[DATA_W-1] == bus.pix_data[DATA_W-1]) &&
                      (sum_d[DATA_W-1] != bus.acc_out[DATA_W-1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_ovf_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      if (state_q == S_CLEAR) begin
        win_ovf_q <= 1'b0;
      end else if (accept_d && term_ovf_d) begin
        win_ovf_q <= 1'b1;
      end
      if (state_q == S_SETTLE) begin
        out_ovf_q <= win_ovf_q;
      end
    end
  end

  assign bus.out_ovf = out_ovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif
endmodule
